// File: rtl/cdc_pkg.sv
// Shared defaults, FSM encoding and saturating-increment helper for the
// egress-domain packet checker.
package cdc_pkg;

  localparam int CDC_WIDTH       = 8;
  localparam int CDC_FRAME_BYTES = 42;
  localparam int CDC_CNT_W       = 16;

  typedef enum logic [1:0] {
    CHK_DRAIN_S,
    CHK_IDLE_S,
    CHK_RECV_S
  } chk_state_e;

  // Increment v, holding at the all-ones value of a w-bit field (w <= 64).
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] max_v;
    max_v = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    return (v >= max_v) ? max_v : v + 64'd1;
  endfunction

endpackage

// File: rtl/cdc_sat_counter.sv
// Saturating statistics counter with synchronous clear; clear wins over increment.
module cdc_sat_counter
  import cdc_pkg::*;
#(
  parameter int CNT_W = CDC_CNT_W
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: step by one, pinned at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i) cnt_d = CNT_W'(sat_inc(64'(cnt_q), CNT_W));
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (clr_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cdc_pkt_checker.sv
// Receive-side packet checker: splits the egress byte stream into valid
// bursts, compares each byte to a loadable expected frame, checks length,
// and keeps per-packet status plus saturating statistics.
module cdc_pkt_checker
  import cdc_pkg::*;
#(
  parameter  int WIDTH       = CDC_WIDTH,
  parameter  int FRAME_BYTES = CDC_FRAME_BYTES,
  parameter  int CNT_W       = CDC_CNT_W,
  localparam int ADDR_W      = $clog2(FRAME_BYTES)
) (
  input  logic              clk_b,
  input  logic              rst,
  input  logic              exp_wr_en,
  input  logic [ADDR_W-1:0] exp_addr,
  input  logic [WIDTH-1:0]  exp_data,
  input  logic              data_valid_b,
  input  logic [WIDTH-1:0]  data_b,
  output logic              busy,
  output logic              pkt_done,
  output logic              pkt_ok,
  output logic [ADDR_W-1:0] first_err_idx,
  output logic [CNT_W-1:0]  pkt_count,
  output logic [CNT_W-1:0]  byte_err_count,
  output logic [CNT_W-1:0]  len_err_count
);

  // The byte index must reach FRAME_BYTES itself to flag an extra byte.
  localparam int IDX_W = $clog2(FRAME_BYTES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES);

  logic [WIDTH-1:0] exp_mem [FRAME_BYTES];

  chk_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] ferr_q, ferr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ok_q, ok_d;
  logic [ADDR_W-1:0] first_q, first_d;
  logic              inc_pkt, inc_byte, inc_len;

  logic [IDX_W-1:0]  rd_idx;
  logic [WIDTH-1:0]  exp_byte;
  logic              mismatch;

  // Expected frame: not reset, frozen while a packet is being received.
  always_ff @(posedge clk_b) begin
    if (exp_wr_en && !busy_q && (IDX_W'(exp_addr) < LAST_IDX))
      exp_mem[exp_addr] <= exp_data;
  end

  // Byte compare against the expected frame at the current index.
  always_comb begin
    rd_idx   = (state_q == CHK_IDLE_S) ? '0 : idx_q;
    exp_byte = '0;
    if (rd_idx < LAST_IDX) exp_byte = exp_mem[ADDR_W'(rd_idx)];
    mismatch = (data_b != exp_byte);
  end

  // State and packet bookkeeping registers.
  always_ff @(posedge clk_b) begin
    if (rst) begin
      state_q <= CHK_DRAIN_S;
      idx_q   <= '0;
      err_q   <= 1'b0;
      ferr_q  <= '1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
      first_q <= '1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ok_q    <= ok_d;
      first_q <= first_d;
    end
  end

  // Next-state: drain any burst in flight, then frame bursts into packets.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CHK_DRAIN_S: if (!data_valid_b) state_d = CHK_IDLE_S;
      CHK_IDLE_S:  if (data_valid_b)  state_d = CHK_RECV_S;
      CHK_RECV_S: begin
        if (!data_valid_b)          state_d = CHK_IDLE_S;
        else if (idx_q == LAST_IDX) state_d = CHK_DRAIN_S;
      end
      default:                      state_d = CHK_DRAIN_S;
    endcase
  end

  // Datapath and status: compare bytes, close packets, raise counter strobes.
  always_comb begin
    idx_d    = idx_q;
    err_d    = err_q;
    ferr_d   = ferr_q;
    busy_d   = (state_d == CHK_RECV_S);
    done_d   = 1'b0;
    ok_d     = ok_q;
    first_d  = first_q;
    inc_pkt  = 1'b0;
    inc_byte = 1'b0;
    inc_len  = 1'b0;
    case (state_q)
      CHK_IDLE_S: begin
        if (data_valid_b) begin
          idx_d    = IDX_W'(1);
          err_d    = mismatch;
          ferr_d   = mismatch ? '0 : '1;
          inc_byte = mismatch;
        end
      end
      CHK_RECV_S: begin
        if (data_valid_b && (idx_q != LAST_IDX)) begin
          inc_byte = mismatch;
          if (mismatch && !err_q) begin
            err_d  = 1'b1;
            ferr_d = ADDR_W'(idx_q);
          end
          idx_d = idx_q + IDX_W'(1);
        end else if (data_valid_b) begin
          // Extra byte: long packet, close it without comparing.
          done_d  = 1'b1;
          ok_d    = 1'b0;
          first_d = ferr_q;
          inc_pkt = 1'b1;
          inc_len = 1'b1;
        end else begin
          done_d  = 1'b1;
          ok_d    = (idx_q == LAST_IDX) && !err_q;
          first_d = ferr_q;
          inc_pkt = 1'b1;
          inc_len = (idx_q != LAST_IDX);
        end
      end
      default: ;
    endcase
  end

  cdc_sat_counter #(.CNT_W(CNT_W)) u_pkt_cnt (
    .clk_i(clk_b), .clr_i(rst), .inc_i(inc_pkt),  .cnt_o(pkt_count)
  );
  cdc_sat_counter #(.CNT_W(CNT_W)) u_byte_err_cnt (
    .clk_i(clk_b), .clr_i(rst), .inc_i(inc_byte), .cnt_o(byte_err_count)
  );
  cdc_sat_counter #(.CNT_W(CNT_W)) u_len_err_cnt (
    .clk_i(clk_b), .clr_i(rst), .inc_i(inc_len),  .cnt_o(len_err_count)
  );

  assign busy          = busy_q;
  assign pkt_done      = done_q;
  assign pkt_ok        = ok_q;
  assign first_err_idx = first_q;

endmodule

// File: tb/tb_cdc_pkt_checker.sv
// Bench for cdc_pkt_checker: scenario tasks driving bursts, checked against a
// packet-level model (byte list vs expected frame, counted per packet).
module tb_cdc_pkt_checker;

  localparam int FB = 42;
  localparam int AW = 6;
  localparam int CW = 16;
  localparam int CMAX = 65535;

  logic          clk_b = 1'b0;
  logic          rst;
  logic          exp_wr_en;
  logic [AW-1:0] exp_addr;
  logic [7:0]    exp_data;
  logic          data_valid_b;
  logic [7:0]    data_b;
  logic          busy, pkt_done, pkt_ok;
  logic [AW-1:0] first_err_idx;
  logic [CW-1:0] pkt_count, byte_err_count, len_err_count;

  cdc_pkt_checker dut (
    .clk_b(clk_b), .rst(rst), .exp_wr_en(exp_wr_en), .exp_addr(exp_addr),
    .exp_data(exp_data), .data_valid_b(data_valid_b), .data_b(data_b),
    .busy(busy), .pkt_done(pkt_done), .pkt_ok(pkt_ok),
    .first_err_idx(first_err_idx), .pkt_count(pkt_count),
    .byte_err_count(byte_err_count), .len_err_count(len_err_count)
  );

  always #5 clk_b = ~clk_b;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] exp_frame [FB];
  logic [7:0] pkt_bytes [64];
  int m_pkt, m_byte, m_len;

  function automatic int sat_add(input int v, input int d);
    return (v + d > CMAX) ? CMAX : v + d;
  endfunction

  task automatic tick();
    @(posedge clk_b); #1;
  endtask

  task automatic wr_exp(input int a, input logic [7:0] d);
    exp_wr_en = 1'b1; exp_addr = AW'(a); exp_data = d;
    tick();
    exp_wr_en = 1'b0;
    if (a < FB) exp_frame[a] = d;
  endtask

  task automatic load_frame(input bit rnd);
    for (int i = 0; i < FB; i++) wr_exp(i, rnd ? 8'($urandom) : 8'(i));
  endtask

  task automatic fill_pkt();
    for (int i = 0; i < 64; i++) pkt_bytes[i] = (i < FB) ? exp_frame[i] : 8'($urandom);
  endtask

  // Send one burst of len bytes from pkt_bytes, then gap+1 idle cycles, and
  // check the packet outcome against the model.
  task automatic run_burst(input int len, input int gap, input bit wr_busy);
    int nerr = 0;
    int ferr = 63;
    bit early = 0;
    bit exp_ok;
    logic g_done, g_ok;
    logic [AW-1:0] g_ferr;
    logic [CW-1:0] g_pc, g_bc, g_lc;
    for (int i = 0; i < ((len < FB) ? len : FB); i++)
      if (pkt_bytes[i] !== exp_frame[i]) begin
        nerr++;
        if (ferr == 63) ferr = i;
      end
    exp_ok = (nerr == 0) && (len == FB);
    m_pkt  = sat_add(m_pkt, 1);
    m_byte = sat_add(m_byte, nerr);
    m_len  = sat_add(m_len, (len != FB) ? 1 : 0);
    g_done = 0; g_ok = 0; g_ferr = 0; g_pc = 0; g_bc = 0; g_lc = 0;
    for (int i = 0; i < len; i++) begin
      data_valid_b = 1'b1; data_b = pkt_bytes[i];
      if (wr_busy && i == 5) begin
        exp_wr_en = 1'b1; exp_addr = AW'(10); exp_data = ~exp_frame[10];
      end
      tick();
      exp_wr_en = 1'b0;
      if (i == 0) begin
        n_chk++;
        if (busy !== 1'b1) begin
          n_fail++; $display("FAIL busy_start: got %b want 1", busy);
        end
      end
      if (i == FB) begin
        g_done = pkt_done; g_ok = pkt_ok; g_ferr = first_err_idx;
        g_pc = pkt_count; g_bc = byte_err_count; g_lc = len_err_count;
      end else if (pkt_done) early = 1;
    end
    data_valid_b = 1'b0;
    tick();
    if (len <= FB) begin
      g_done = pkt_done; g_ok = pkt_ok; g_ferr = first_err_idx;
      g_pc = pkt_count; g_bc = byte_err_count; g_lc = len_err_count;
    end
    n_chk += 7;
    if (early) begin n_fail++; $display("FAIL done_early: len=%0d", len); end
    if (g_done !== 1'b1) begin n_fail++; $display("FAIL pkt_done: len=%0d got %b want 1", len, g_done); end
    if (g_ok !== exp_ok) begin n_fail++; $display("FAIL pkt_ok: len=%0d got %b want %b", len, g_ok, exp_ok); end
    if (g_ferr !== AW'(ferr)) begin n_fail++; $display("FAIL first_err_idx: got %0d want %0d", g_ferr, ferr); end
    if (g_pc !== CW'(m_pkt)) begin n_fail++; $display("FAIL pkt_count: got %0d want %0d", g_pc, m_pkt); end
    if (g_bc !== CW'(m_byte)) begin n_fail++; $display("FAIL byte_err_count: got %0d want %0d", g_bc, m_byte); end
    if (g_lc !== CW'(m_len)) begin n_fail++; $display("FAIL len_err_count: got %0d want %0d", g_lc, m_len); end
    repeat (gap) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; exp_wr_en = 1'b0; exp_addr = '0; exp_data = '0;
    data_valid_b = 1'b0; data_b = '0;
    tick(); tick();
    n_chk++;
    if ({busy, pkt_done, pkt_ok, first_err_idx, pkt_count, byte_err_count, len_err_count}
        !== {3'b000, 6'h3f, 48'h0}) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b ok=%b ferr=%0d pc=%0d bc=%0d lc=%0d want 0 0 0 63 0 0 0",
               busy, pkt_done, pkt_ok, first_err_idx, pkt_count, byte_err_count, len_err_count);
    end
    rst = 1'b0;
    m_pkt = 0; m_byte = 0; m_len = 0;
    tick();
  endtask

  task automatic test_good();
    load_frame(0);
    fill_pkt();
    run_burst(FB, 1, 0);
  endtask

  task automatic test_byte_err();
    fill_pkt();
    pkt_bytes[5] = ~pkt_bytes[5];
    pkt_bytes[17] = ~pkt_bytes[17];
    run_burst(FB, 1, 0);
    // Mismatch on the very first byte.
    fill_pkt();
    pkt_bytes[0] = ~pkt_bytes[0];
    run_burst(FB, 0, 0);
  endtask

  task automatic test_short();
    fill_pkt();
    run_burst(FB - 1, 1, 0);
  endtask

  task automatic test_long();
    fill_pkt();
    run_burst(FB + 4, 0, 0);
    fill_pkt();
    run_burst(FB, 1, 0);
  endtask

  task automatic test_mem_guard();
    // Writes past the frame and during a packet must not disturb the frame.
    for (int a = FB; a < 64; a++) wr_exp(a, 8'($urandom));
    fill_pkt();
    run_burst(FB, 0, 1);
    fill_pkt();
    run_burst(FB, 0, 0);
  endtask

  task automatic test_back_to_back();
    for (int p = 0; p < 200; p++) begin fill_pkt(); run_burst(FB, 10, 0); end
    for (int p = 0; p < 50; p++) begin fill_pkt(); run_burst(FB, 0, 0); end
  endtask

  task automatic test_random();
    load_frame(1);
    for (int p = 0; p < 40; p++) begin
      int len;
      len = $urandom_range(FB + 4, FB - 4);
      fill_pkt();
      for (int i = 0; i < FB; i++)
        if ($urandom_range(7, 0) == 0) pkt_bytes[i] = pkt_bytes[i] ^ 8'($urandom_range(255, 1));
      run_burst(len, $urandom_range(3, 0), 0);
    end
  endtask

  task automatic test_mid_reset();
    bit seen_done = 0;
    fill_pkt();
    for (int i = 0; i < 20; i++) begin
      data_valid_b = 1'b1; data_b = pkt_bytes[i]; tick();
    end
    rst = 1'b1; data_b = pkt_bytes[20];
    tick();
    rst = 1'b0;
    m_pkt = 0; m_byte = 0; m_len = 0;
    n_chk++;
    if ({busy, pkt_done, pkt_ok, first_err_idx, pkt_count, byte_err_count, len_err_count}
        !== {3'b000, 6'h3f, 48'h0}) begin
      n_fail++;
      $display("FAIL mid_reset_state: busy=%b done=%b ok=%b ferr=%0d pc=%0d bc=%0d lc=%0d",
               busy, pkt_done, pkt_ok, first_err_idx, pkt_count, byte_err_count, len_err_count);
    end
    for (int i = 21; i < FB; i++) begin
      data_b = ~pkt_bytes[i]; tick();
      if (pkt_done || busy) seen_done = 1;
    end
    data_valid_b = 1'b0;
    tick();
    if (pkt_done) seen_done = 1;
    n_chk += 2;
    if (seen_done) begin n_fail++; $display("FAIL drain_ignored: got activity want none"); end
    if ({pkt_count, byte_err_count, len_err_count} !== 48'h0) begin
      n_fail++;
      $display("FAIL drain_counts: pc=%0d bc=%0d lc=%0d want 0 0 0", pkt_count, byte_err_count, len_err_count);
    end
    fill_pkt();
    run_burst(FB, 1, 0);
  endtask

  initial begin
    test_reset();
    test_good();
    test_byte_err();
    test_short();
    test_long();
    test_mem_guard();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
